// File: rtl/gray_convert.sv
// Streaming RGB-to-gray stage: pops packed RGB from a FWFT FIFO, computes a
// weighted luma in two pipeline stages and pushes gray pixels with a frame-end flag.
module gray_convert #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned IMAGE_WIDTH  = 720,
  parameter int unsigned IMAGE_HEIGHT = 540,
  parameter int unsigned W_R          = 77,
  parameter int unsigned W_G          = 150,
  parameter int unsigned W_B          = 29
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_empty,
  input  logic [3*DATA_WIDTH-1:0] rgb_in,
  input  logic                    output_full,
  output logic                    read_fifo,
  output logic                    write_fifo,
  output logic [DATA_WIDTH-1:0]   gray_out,
  output logic                    frame_end
);

  localparam int unsigned ProdW   = 2 * DATA_WIDTH;
  localparam int unsigned SumW    = ProdW + 2;
  localparam int unsigned NumPix  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned CntW    = (NumPix > 1) ? $clog2(NumPix) : 1;
  localparam logic [CntW-1:0] LastPix = CntW'(NumPix - 1);
  localparam logic [SumW-1:0] MaxGray = SumW'((1 << DATA_WIDTH) - 1);
  localparam logic [SumW-1:0] Round   = SumW'(128);

  logic [DATA_WIDTH-1:0] chan_r, chan_g, chan_b;
  assign chan_r = rgb_in[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign chan_g = rgb_in[2*DATA_WIDTH-1:DATA_WIDTH];
  assign chan_b = rgb_in[DATA_WIDTH-1:0];

  logic [ProdW-1:0]      pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  logic                  v1_q, v1_d, v2_q, v2_d;
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  logic [CntW-1:0]       pix_cnt_q, pix_cnt_d;

  logic            advance;
  logic [SumW-1:0] sum, scaled;

  // Stage 2 can take a new value whenever it is empty or its value is being pushed.
  always_comb begin
    advance    = !v2_q || !output_full;
    read_fifo  = !rst && !input_empty && advance;
    write_fifo = !rst && v2_q && !output_full;
    frame_end  = write_fifo && (pix_cnt_q == LastPix);
  end

  assign gray_out = gray_q;

  // Weights are Q0.8: round by adding half an LSB, then drop the 8 fraction bits.
  always_comb begin
    sum    = SumW'(pr_q) + SumW'(pg_q) + SumW'(pb_q) + Round;
    scaled = sum >> 8;
  end

  always_comb begin
    pr_d      = pr_q;
    pg_d      = pg_q;
    pb_d      = pb_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    gray_d    = gray_q;
    pix_cnt_d = pix_cnt_q;

    if (advance) begin
      v1_d = read_fifo;
      if (read_fifo) begin
        pr_d = ProdW'(chan_r) * ProdW'(W_R);
        pg_d = ProdW'(chan_g) * ProdW'(W_G);
        pb_d = ProdW'(chan_b) * ProdW'(W_B);
      end
      v2_d   = v1_q;
      gray_d = (scaled > MaxGray) ? {DATA_WIDTH{1'b1}} : scaled[DATA_WIDTH-1:0];
    end

    if (write_fifo) begin
      pix_cnt_d = (pix_cnt_q == LastPix) ? '0 : pix_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_q      <= '0;
      pg_q      <= '0;
      pb_q      <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      gray_q    <= '0;
      pix_cnt_q <= '0;
    end else begin
      pr_q      <= pr_d;
      pg_q      <= pg_d;
      pb_q      <= pb_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      gray_q    <= gray_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

endmodule

// File: tb/tb_gray_convert.sv
// Self-checking bench for gray_convert: in-order scoreboard of in-flight pixels
// plus directed literal checks, driven by an environment-side FWFT FIFO queue.
module tb_gray_convert;

  localparam int NPIX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        input_empty = 1'b1;
  logic        output_full = 1'b0;
  logic [23:0] rgb_in = '0;
  logic        read_fifo, write_fifo, frame_end;
  logic [7:0]  gray_out;

  gray_convert #(
    .DATA_WIDTH  (8),
    .IMAGE_WIDTH (4),
    .IMAGE_HEIGHT(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .input_empty(input_empty),
    .rgb_in     (rgb_in),
    .output_full(output_full),
    .read_fifo  (read_fifo),
    .write_fifo (write_fifo),
    .gray_out   (gray_out),
    .frame_end  (frame_end)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned in_q[$];   // environment input FIFO contents
  int unsigned fl[$];     // pixels popped but not yet written, oldest first
  int          ages[$];   // advancing edges seen by each in-flight pixel
  int          wcnt = 0;  // writes modulo frame size
  bit          started = 1'b0;
  bit          gap = 1'b0;
  int unsigned wlog[$];
  bit          fel[$];
  int          both_cnt = 0;

  bit m_ready, m_adv, m_read, m_write, m_fe;

  function automatic int unsigned luma(int unsigned p);
    int unsigned s;
    s = ((p >> 16) & 255) * 77 + ((p >> 8) & 255) * 150 + (p & 255) * 29 + 128;
    s = s >> 8;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: expected handshakes derived from the in-flight list.
  always @(negedge clk) begin
    if (started) begin
      m_ready = (ages.size() > 0) && (ages[0] >= 2);
      m_adv   = !m_ready || !output_full;
      m_read  = !rst && !input_empty && m_adv;
      m_write = !rst && m_ready && !output_full;
      m_fe    = m_write && (wcnt == NPIX - 1);
      chk("read_fifo", read_fifo, m_read);
      chk("write_fifo", write_fifo, m_write);
      chk("frame_end", frame_end, m_fe);
      if (m_ready) chk("gray_out", gray_out, luma(fl[0]));
      if (write_fifo) begin
        wlog.push_back(gray_out);
        fel.push_back(frame_end);
      end
      if (read_fifo && write_fifo) both_cnt++;
    end
  end

  // Model update on the clock edge, using the handshakes predicted above.
  always @(posedge clk) begin
    if (started) begin
      if (rst) begin
        fl.delete();
        ages.delete();
        wcnt = 0;
      end else if (m_adv) begin
        if (m_write) begin
          void'(fl.pop_front());
          void'(ages.pop_front());
          wcnt = (wcnt + 1) % NPIX;
        end
        foreach (ages[i]) ages[i] = ages[i] + 1;
        if (m_read && in_q.size() > 0) begin
          fl.push_back(in_q[0]);
          ages.push_back(1);
        end
      end
      if (read_fifo && in_q.size() > 0) void'(in_q.pop_front());
    end
  end

  task automatic sync_in();
    input_empty = gap || (in_q.size() == 0);
    rgb_in      = (in_q.size() != 0) ? 24'(in_q[0]) : 24'($urandom);
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      sync_in();
    end
  endtask

  task automatic push(int unsigned p);
    in_q.push_back(p & 24'hFFFFFF);
    sync_in();
  endtask

  task automatic drained(string name);
    chk({name, "_in_q"}, in_q.size(), 0);
    chk({name, "_flight"}, fl.size(), 0);
  endtask

  int unsigned pix[6] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h6496C8};
  int unsigned lit[6] = '{255, 0, 77, 149, 29, 141};

  initial begin
    started = 1'b1;
    rst = 1'b1;
    sync_in();
    run(2);
    chk("rst_gray", gray_out, 0);
    chk("rst_frame_end", frame_end, 0);
    chk("rst_read", read_fifo, 0);
    chk("rst_write", write_fifo, 0);
    rst = 1'b0;
    run(1);

    // Single pixels against hand-computed luma values.
    wlog.delete();
    for (int i = 0; i < 6; i++) begin
      push(pix[i]);
      run(5);
    end
    chk("single_count", wlog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wlog.size()) chk("single_value", wlog[i], lit[i]);
    end

    // Continuous stream: full throughput once the pipe fills.
    wlog.delete();
    both_cnt = 0;
    for (int i = 0; i < 20; i++) push(24'h102030 + i * 24'h0B1733);
    run(26);
    chk("stream_count", wlog.size(), 20);
    chk("stream_both_high", both_cnt, 18);
    drained("stream");

    // Backpressure for 5 cycles mid-stream.
    wlog.delete();
    for (int i = 0; i < 20; i++) push($urandom);
    run(6);
    output_full = 1'b1;
    run(5);
    output_full = 1'b0;
    run(30);
    chk("stall_count", wlog.size(), 20);
    drained("stall");

    // Input gaps every other cycle.
    wlog.delete();
    for (int i = 0; i < 16; i++) push($urandom);
    repeat (40) begin
      gap = !gap;
      sync_in();
      run(1);
    end
    gap = 1'b0;
    sync_in();
    run(6);
    chk("gap_count", wlog.size(), 16);
    drained("gap");

    // Two frames of 8 pixels after a fresh reset.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    wlog.delete();
    fel.delete();
    for (int i = 0; i < 16; i++) push($urandom);
    run(24);
    chk("frame_count", wlog.size(), 16);
    if (fel.size() == 16) begin
      chk("frame_end_8th", fel[7], 1);
      chk("frame_end_16th", fel[15], 1);
      chk("frame_end_total", fel.sum() with (int'(item)), 2);
    end

    // Reset with two pixels in flight: they are discarded, count restarts.
    wlog.delete();
    fel.delete();
    for (int i = 0; i < 3; i++) push($urandom);
    run(2);
    rst = 1'b1;
    sync_in();
    run(1);
    rst = 1'b0;
    sync_in();
    for (int i = 0; i < 7; i++) push($urandom);
    run(20);
    chk("midrst_count", wlog.size(), 8);
    if (fel.size() == 8) begin
      chk("midrst_frame_end", fel[7], 1);
      chk("midrst_fe_total", fel.sum() with (int'(item)), 1);
    end
    drained("midrst");

    // Randomized traffic with backpressure, gaps and occasional reset.
    repeat (600) begin
      if ($urandom_range(1, 0) == 1 && in_q.size() < 8) in_q.push_back($urandom & 24'hFFFFFF);
      output_full = ($urandom_range(3, 0) == 0);
      gap         = ($urandom_range(4, 0) == 0);
      rst         = ($urandom_range(80, 0) == 0);
      sync_in();
      run(1);
    end
    output_full = 1'b0;
    gap = 1'b0;
    rst = 1'b0;
    sync_in();
    run(30);
    drained("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_convert.md
Name: gray_convert

Overview:
- Streaming RGB-to-grayscale stage directly upstream of the Sobel edge stage; its output FIFO is the Sobel input FIFO.
- Pops packed 24-bit RGB pixels from a first-word-fall-through (FWFT) input FIFO and computes a weighted-luma gray value in a 2-stage pipeline.
- Pushes the 8-bit result to the output FIFO and flags the last pixel of each frame.

Parameters:
- DATA_WIDTH, 8, bits per colour channel and per gray output.
- IMAGE_WIDTH, 720, pixels per line.
- IMAGE_HEIGHT, 540, lines per frame.
- W_R, 77, red weight (Q0.8).
- W_G, 150, green weight (Q0.8).
- W_B, 29, blue weight (Q0.8).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- input_empty  input  1  input FIFO empty.
- rgb_in  input  3*DATA_WIDTH  FWFT head word, {R[23:16], G[15:8], B[7:0]}; valid when !input_empty.
- output_full  input  1  output FIFO full.
- read_fifo  output  1  pop input FIFO this cycle; combinational.
- write_fifo  output  1  push gray_out this cycle; combinational from registers.
- gray_out  output  DATA_WIDTH  gray pixel; registered.
- frame_end  output  1  high together with write_fifo for the last pixel of a frame.

Behaviour:
- Reset: clk and rst as stated above. While rst is high, read_fifo=0 and write_fifo=0, so nothing moves during reset. On the reset edge: v1=0, v2=0, gray_out=0, pix_cnt=0; frame_end reads 0.
- Stage 1 registers: products pr=R*W_R, pg=G*W_G, pb=B*W_B (2*DATA_WIDTH bits each), plus valid bit v1.
- Stage 2 registers: gray_out and valid bit v2.
- advance = !v2 || !output_full.
- read_fifo = !rst && !input_empty && advance.
- write_fifo = !rst && v2 && !output_full.
- On a clock edge with advance=1:
  - v1 <= read_fifo; products load from rgb_in when read_fifo=1.
  - v2 <= v1; gray_out <= sat((pr+pg+pb+128) >> 8).
- On a clock edge with advance=0: all pipeline registers hold.
- Sum width: 2*DATA_WIDTH+2 bits, so there is no overflow. sat() clamps results above 255 to 255. With the default weights (sum 256) no clamping occurs.
- Latency: a pixel popped at cycle N is written at cycle N+2 when output_full stays low. Throughput is 1 pixel/clk.
- Backpressure:
  - output_full high with v2=1: gray_out holds.
  - If v1=1 as well, read_fifo drops the same cycle.
  - At most 2 pixels are in flight. No drop, no duplication, order preserved.
- Bubble collapse: when v2=0, a pending stage-1 pixel advances even if output_full is high.
- input_empty high: no pop; bubbles propagate; v2 may go 0.
- Frame counter: pix_cnt increments on each write_fifo.
- frame_end = write_fifo && (pix_cnt == IMAGE_WIDTH*IMAGE_HEIGHT-1). That write wraps pix_cnt to 0.
- Counter width: $clog2(IMAGE_WIDTH*IMAGE_HEIGHT).
- Simultaneous pop and push in one cycle is the normal steady state and is legal.
- Reset mid-operation: in-flight pixels are discarded and the frame count restarts at 0. Input FIFO words not yet popped are untouched.

Test Plan:
- Single pixels with output_full=0: rgb_in 0xFFFFFF->255, 0x000000->0, 0xFF0000->77, 0x00FF00->149, 0x0000FF->29, 0x6496C8 (100,150,200)->141. Each write_fifo appears exactly 2 cycles after its read_fifo.
- Continuous stream of 20 distinct pixels, output_full=0: read_fifo and write_fifo both high every cycle once the pipe is filled; outputs in input order; 2-cycle latency.
- Stream with output_full held high for 5 cycles mid-stream:
  - gray_out stable while output_full is high;
  - read_fifo low once v1 and v2 are both set;
  - after release, all pixels emerge in order with none lost or repeated.
- input_empty toggled every other cycle: exactly one write per popped pixel; write_fifo gaps mirror the input gaps.
- IMAGE_WIDTH=4, IMAGE_HEIGHT=2, 16 pixels streamed: frame_end high only on the 8th and 16th writes.
- rst asserted for 1 cycle with 2 pixels in flight: read_fifo and write_fifo low during rst; the 2 in-flight pixels never appear; the next frame_end comes after 8 further writes (IMAGE_WIDTH=4, IMAGE_HEIGHT=2).
